// File: rtl/pcs_sync_param.sv
// pcs_sync_param
// 1000BASE-X receive code-group synchronisation with parametrised thresholds.
// The block acquires comma alignment, tracks the even/odd code-group position and
// runs an error-level ladder while in sync. It also forwards the PUDI stream as
// SUDI one cycle later, tagged with the even flag that applied to it.
module pcs_sync_param #(
   parameter int ACQ_COMMAS   = 3,
   parameter int ERR_LEVELS   = 4,
   parameter int GOOD_CGS_MAX = 3,
   parameter int CNT_W        = 8,
   localparam int EW          = (ERR_LEVELS > 1) ? $clog2(ERR_LEVELS) : 1
) (
   input  logic             GTX_CLK,
   input  logic             RESET,
   input  logic [9:0]       PUDI,
   input  logic             PUDI_valid,
   input  logic             cg_invalid,
   input  logic             SIGNAL_DETECT,
   input  logic             MR_LOOPBACK,
   output logic             sync_status,
   output logic             rx_even,
   output logic [9:0]       SUDI,
   output logic             SUDI_even,
   output logic             SUDI_valid,
   output logic             sync_lost,
   output logic [EW-1:0]    err_lvl,
   output logic [CNT_W-1:0] loss_cnt
);

   // acq_cnt only ever reaches ACQ_COMMAS; good_cnt only ever reaches GOOD_CGS_MAX
   localparam int AW = (ACQ_COMMAS > 0) ? $clog2(ACQ_COMMAS + 1) : 1;
   localparam int GW = (GOOD_CGS_MAX > 0) ? $clog2(GOOD_CGS_MAX + 1) : 1;

   localparam logic [AW-1:0] ACQ_LAST  = AW'(ACQ_COMMAS);
   localparam logic [EW-1:0] ERR_LAST  = EW'(ERR_LEVELS - 1);
   localparam logic [GW-1:0] GOOD_LAST = GW'(GOOD_CGS_MAX);

   typedef enum logic [1:0] {
      S_LOSS  = 2'd0,   // hunting for any comma
      S_COMMA = 2'd1,   // comma seen, waiting for the data cg that must follow
      S_ACQ   = 2'd2,   // between commas during acquisition
      S_SYNC  = 2'd3    // aligned, error ladder active
   } state_t;

   state_t           state_q, state_d;
   logic [AW-1:0]    acq_cnt_q, acq_cnt_d;
   logic [EW-1:0]    err_lvl_q, err_lvl_d;
   logic [GW-1:0]    good_cnt_q, good_cnt_d;
   logic             rx_even_q, rx_even_d;
   logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;
   logic             sync_lost_q, sync_lost_d;
   logic [9:0]       sudi_q;
   logic             sudi_even_q;
   logic             sudi_valid_q;

   logic sig_ok;
   logic comma;
   logic cgbad;
   logic data_cg;

   // Code-group classification; cgbad includes a comma landing on an odd position
   always_comb begin
      sig_ok  = SIGNAL_DETECT | MR_LOOPBACK;
      comma   = (PUDI[9:3] == 7'b0011111) | (PUDI[9:3] == 7'b1100000);
      cgbad   = cg_invalid | (comma & rx_even_q);
      data_cg = ~comma & ~cg_invalid;
   end

   // Next-state and counter updates; loss of signal overrides everything
   always_comb begin
      state_d     = state_q;
      acq_cnt_d   = acq_cnt_q;
      err_lvl_d   = err_lvl_q;
      good_cnt_d  = good_cnt_q;
      rx_even_d   = rx_even_q;
      loss_cnt_d  = loss_cnt_q;
      sync_lost_d = 1'b0;

      if (!sig_ok) begin
         state_d    = S_LOSS;
         acq_cnt_d  = '0;
         err_lvl_d  = '0;
         good_cnt_d = '0;
         // leaving S_SYNC by loss of signal is still a sync loss
         if (state_q == S_SYNC) begin
            sync_lost_d = 1'b1;
            if (loss_cnt_q != '1) loss_cnt_d = loss_cnt_q + 1'b1;
         end
      end else if (PUDI_valid) begin
         // default per valid cg: position alternates
         rx_even_d = ~rx_even_q;
         unique case (state_q)
            S_LOSS: begin
               if (comma) begin
                  state_d   = S_COMMA;
                  rx_even_d = 1'b1;
                  acq_cnt_d = AW'(1);
               end
            end
            S_COMMA: begin
               rx_even_d = 1'b0;
               if (data_cg) begin
                  if (acq_cnt_q == ACQ_LAST) begin
                     state_d    = S_SYNC;
                     err_lvl_d  = '0;
                     good_cnt_d = '0;
                  end else begin
                     state_d = S_ACQ;
                  end
               end else begin
                  state_d   = S_LOSS;
                  acq_cnt_d = '0;
               end
            end
            S_ACQ: begin
               if (cgbad) begin
                  state_d   = S_LOSS;
                  acq_cnt_d = '0;
               end else if (comma) begin
                  // cgbad is clear, so this comma sits on an even position
                  state_d   = S_COMMA;
                  rx_even_d = 1'b1;
                  if (acq_cnt_q != ACQ_LAST) acq_cnt_d = acq_cnt_q + 1'b1;
               end
            end
            S_SYNC: begin
               if (comma) rx_even_d = 1'b1;
               if (cgbad) begin
                  if (err_lvl_q == ERR_LAST) begin
                     state_d     = S_LOSS;
                     sync_lost_d = 1'b1;
                     acq_cnt_d   = '0;
                     err_lvl_d   = '0;
                     good_cnt_d  = '0;
                     if (loss_cnt_q != '1) loss_cnt_d = loss_cnt_q + 1'b1;
                  end else begin
                     err_lvl_d  = err_lvl_q + 1'b1;
                     good_cnt_d = '0;
                  end
               end else if (err_lvl_q != '0) begin
                  // a run of GOOD_CGS_MAX+1 good cgs repays one error level
                  if (good_cnt_q == GOOD_LAST) begin
                     err_lvl_d  = err_lvl_q - 1'b1;
                     good_cnt_d = '0;
                  end else begin
                     good_cnt_d = good_cnt_q + 1'b1;
                  end
               end
            end
            default: begin
               state_d   = S_LOSS;
               acq_cnt_d = '0;
            end
         endcase
      end
   end

   // Synchroniser state and counters
   always_ff @(posedge GTX_CLK or negedge RESET) begin
      if (!RESET) begin
         state_q     <= S_LOSS;
         acq_cnt_q   <= '0;
         err_lvl_q   <= '0;
         good_cnt_q  <= '0;
         rx_even_q   <= 1'b0;
         loss_cnt_q  <= '0;
         sync_lost_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acq_cnt_q   <= acq_cnt_d;
         err_lvl_q   <= err_lvl_d;
         good_cnt_q  <= good_cnt_d;
         rx_even_q   <= rx_even_d;
         loss_cnt_q  <= loss_cnt_d;
         sync_lost_q <= sync_lost_d;
      end
   end

   // SUDI pipeline: forward each valid cg with the pre-update even flag
   always_ff @(posedge GTX_CLK or negedge RESET) begin
      if (!RESET) begin
         sudi_q       <= '0;
         sudi_even_q  <= 1'b0;
         sudi_valid_q <= 1'b0;
      end else begin
         sudi_valid_q <= PUDI_valid;
         if (PUDI_valid) begin
            sudi_q      <= PUDI;
            sudi_even_q <= rx_even_q;
         end
      end
   end

   assign sync_status = (state_q == S_SYNC);
   assign rx_even     = rx_even_q;
   assign SUDI        = sudi_q;
   assign SUDI_even   = sudi_even_q;
   assign SUDI_valid  = sudi_valid_q;
   assign sync_lost   = sync_lost_q;
   assign err_lvl     = err_lvl_q;
   assign loss_cnt    = loss_cnt_q;

endmodule

// File: tb/tb_pcs_sync_param.sv
// Bench for pcs_sync_param: directed scenarios then random traffic, checked
// against a flag-based reference model and a SUDI scoreboard.
module tb_pcs_sync_param;
   localparam int ACQ  = 3;
   localparam int ERRL = 4;
   localparam int GMAX = 3;

   localparam logic [9:0] K_NEG = 10'b0011111010;
   localparam logic [9:0] K_POS = 10'b1100000101;
   localparam logic [9:0] D162  = 10'b1001000101;

   logic       GTX_CLK = 1'b0;
   logic       RESET = 1'b0;
   logic [9:0] PUDI = '0;
   logic       PUDI_valid = 1'b0;
   logic       cg_invalid = 1'b0;
   logic       SIGNAL_DETECT = 1'b1;
   logic       MR_LOOPBACK = 1'b0;
   logic       sync_status, rx_even, SUDI_even, SUDI_valid, sync_lost;
   logic [9:0] SUDI;
   logic [1:0] err_lvl;
   logic [7:0] loss_cnt;

   pcs_sync_param #(.ACQ_COMMAS(ACQ), .ERR_LEVELS(ERRL), .GOOD_CGS_MAX(GMAX), .CNT_W(8)) dut (
      .GTX_CLK(GTX_CLK), .RESET(RESET), .PUDI(PUDI), .PUDI_valid(PUDI_valid),
      .cg_invalid(cg_invalid), .SIGNAL_DETECT(SIGNAL_DETECT), .MR_LOOPBACK(MR_LOOPBACK),
      .sync_status(sync_status), .rx_even(rx_even), .SUDI(SUDI), .SUDI_even(SUDI_even),
      .SUDI_valid(SUDI_valid), .sync_lost(sync_lost), .err_lvl(err_lvl), .loss_cnt(loss_cnt)
   );

   always #5 GTX_CLK = ~GTX_CLK;

   typedef struct {
      logic [9:0] cg;
      logic       even;
      int         sync;
      int         err;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int n_vec = 0;
   int n_err = 0;
   int n_pulse = 0;

   // reference model: sync flag, commas counted so far, waiting-for-data flag
   int m_sync, m_commas, m_wait, m_even, m_err, m_good, m_loss, m_lost;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   function automatic bit is_comma(input logic [9:0] cg);
      return (cg[9:3] == 7'b0011111) || (cg[9:3] == 7'b1100000);
   endfunction

   function automatic logic [9:0] rand_data();
      logic [9:0] r;
      r = 10'($urandom);
      while (is_comma(r)) r = 10'($urandom);
      return r;
   endfunction

   task automatic model_reset();
      m_sync = 0; m_commas = 0; m_wait = 0; m_even = 0;
      m_err = 0; m_good = 0; m_loss = 0;
   endtask

   task automatic model_step(input logic [9:0] cg, input bit inv, input bit v,
                             input bit sd, input bit lb);
      bit c, bad, dat;
      exp_t e;
      c   = is_comma(cg);
      bad = inv || (c && m_even == 1);
      dat = !c && !inv;
      e.cg   = cg;
      e.even = (m_even != 0);
      if (!(sd || lb)) begin
         if (m_sync != 0) begin
            m_lost++;
            if (m_loss < 255) m_loss++;
         end
         m_sync = 0; m_commas = 0; m_wait = 0; m_err = 0; m_good = 0;
      end else if (v) begin
         if (m_sync != 0) begin
            m_even = c ? 1 : 1 - m_even;
            if (bad) begin
               if (m_err == ERRL - 1) begin
                  m_sync = 0; m_commas = 0; m_err = 0; m_good = 0;
                  m_lost++;
                  if (m_loss < 255) m_loss++;
               end else begin
                  m_err++; m_good = 0;
               end
            end else if (m_err > 0) begin
               if (m_good == GMAX) begin m_err--; m_good = 0; end
               else m_good++;
            end
         end else if (m_wait != 0) begin
            m_even = 0; m_wait = 0;
            if (dat) begin
               if (m_commas == ACQ) begin m_sync = 1; m_err = 0; m_good = 0; end
            end else m_commas = 0;
         end else if (m_commas > 0) begin
            if (bad) begin m_commas = 0; m_even = 1 - m_even; end
            else if (c) begin m_commas++; m_wait = 1; m_even = 1; end
            else m_even = 1 - m_even;
         end else begin
            if (c) begin m_commas = 1; m_wait = 1; m_even = 1; end
            else m_even = 1 - m_even;
         end
      end
      e.sync = m_sync;
      e.err  = m_err;
      if (v) q.push_back(e);
   endtask

   // one cycle: check current state against the model, then drive the next inputs
   task automatic cyc(input logic [9:0] cg, input bit inv, input bit v,
                      input bit sd = 1'b1, input bit lb = 1'b0);
      @(negedge GTX_CLK);
      chk("sync_status", int'(sync_status), m_sync);
      chk("err_lvl", int'(err_lvl), m_err);
      chk("loss_cnt", int'(loss_cnt), m_loss);
      chk("rx_even", int'(rx_even), m_even);
      PUDI = cg; cg_invalid = inv; PUDI_valid = v; SIGNAL_DETECT = sd; MR_LOOPBACK = lb;
      model_step(cg, inv, v, sd, lb);
   endtask

   task automatic idle();
      cyc(10'h000, 1'b0, 1'b0);
   endtask

   task automatic peek();
      @(posedge GTX_CLK);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_sync"}, int'(sync_status), 0);
      chk({tag, "_rx_even"}, int'(rx_even), 0);
      chk({tag, "_sudi"}, int'(SUDI), 0);
      chk({tag, "_sudi_even"}, int'(SUDI_even), 0);
      chk({tag, "_sudi_valid"}, int'(SUDI_valid), 0);
      chk({tag, "_sync_lost"}, int'(sync_lost), 0);
      chk({tag, "_err_lvl"}, int'(err_lvl), 0);
      chk({tag, "_loss_cnt"}, int'(loss_cnt), 0);
   endtask

   // scoreboard monitor: every SUDI strobe must match the oldest pending cg
   always @(negedge GTX_CLK) begin
      if (sync_lost) n_pulse++;
      if (SUDI_valid) begin
         if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sudi_strobe: got unexpected strobe, want none");
         end else begin
            mon_e = q.pop_front();
            chk("SUDI", int'(SUDI), int'(mon_e.cg));
            chk("SUDI_even", int'(SUDI_even), int'(mon_e.even));
            chk("sb_sync", int'(sync_status), mon_e.sync);
            chk("sb_err", int'(err_lvl), mon_e.err);
         end
      end
   end

   initial begin
      bit v, inv, sd, lb;
      int ph;
      logic [9:0] cg;

      model_reset();
      m_lost = 0;
      #1;
      chk_all_zero("reset");
      @(negedge GTX_CLK);
      RESET = 1'b1;

      // 1: three comma/data pairs acquire sync
      for (int j = 0; j < 3; j++) begin
         cyc(K_NEG, 0, 1);
         cyc(D162, 0, 1);
      end
      peek();
      chk("t1_sync", int'(sync_status), 1);

      // 2: one bad cg, repaid by four good ones
      cyc(D162, 1, 1);
      peek();
      chk("t2_err_up", int'(err_lvl), 1);
      repeat (3) cyc(D162, 0, 1);
      peek();
      chk("t2_err_hold", int'(err_lvl), 1);
      cyc(D162, 0, 1);
      peek();
      chk("t2_err_down", int'(err_lvl), 0);
      chk("t2_sync", int'(sync_status), 1);

      // 3: four bad cgs, three good between each, end in loss
      for (int k = 0; k < 4; k++) begin
         cyc(D162, 1, 1);
         peek();
         if (k < 3) begin
            chk("t3_err", int'(err_lvl), k + 1);
            repeat (3) cyc(D162, 0, 1);
         end
      end
      chk("t3_sync", int'(sync_status), 0);
      chk("t3_lost", int'(sync_lost), 1);
      chk("t3_loss_cnt", int'(loss_cnt), 1);

      // 4: comma at odd position during acquisition, then fresh acquisition
      cyc(K_NEG, 0, 1);
      cyc(D162, 0, 1);
      cyc(D162, 0, 1);
      cyc(K_POS, 0, 1);
      peek();
      chk("t4_sync", int'(sync_status), 0);
      for (int j = 0; j < 3; j++) begin
         cyc(K_NEG, 0, 1);
         cyc(D162, 0, 1);
         peek();
         chk("t4_acq", int'(sync_status), (j == 2) ? 1 : 0);
      end

      // 5: loss of signal drops sync; loopback masks it
      cyc(D162, 0, 0, 0, 0);
      peek();
      chk("t5_sync", int'(sync_status), 0);
      chk("t5_lost", int'(sync_lost), 1);
      chk("t5_loss_cnt", int'(loss_cnt), 2);
      for (int j = 0; j < 3; j++) begin
         cyc(K_NEG, 0, 1);
         cyc(D162, 0, 1);
      end
      for (int j = 0; j < 2; j++) begin
         cyc(K_POS, 0, 1, 0, 1);
         cyc(D162, 0, 1, 0, 1);
      end
      peek();
      chk("t5_lb_sync", int'(sync_status), 1);
      chk("t5_lb_loss_cnt", int'(loss_cnt), 2);

      // 6: acquisition with valid gaps
      cyc(D162, 0, 0, 0, 0);
      for (int j = 0; j < 6; j++) begin
         cyc((j % 2 == 0) ? K_NEG : D162, 0, 1);
         if (j < 5) repeat (5) idle();
         if (j == 4) begin
            peek();
            chk("t6_pre", int'(sync_status), 0);
         end
      end
      peek();
      chk("t6_sync", int'(sync_status), 1);

      // async reset in sync
      idle();
      @(posedge GTX_CLK);
      #3;
      RESET = 1'b0;
      #1;
      chk_all_zero("areset");
      chk("areset_q", q.size(), 0);
      model_reset();
      @(negedge GTX_CLK);
      RESET = 1'b1;

      // random traffic, biased toward well-formed comma/data alternation
      ph = 0;
      for (int i = 0; i < 3000; i++) begin
         v   = ($urandom % 8) != 0;
         inv = ($urandom % 100) < 3;
         sd  = ($urandom % 150) != 0;
         lb  = ($urandom % 4) == 0;
         if (($urandom % 100) < 4)
            cg = ($urandom % 2) ? K_NEG : K_POS;
         else if (ph == 0 && ($urandom % 100) < 85)
            cg = ($urandom % 2) ? K_NEG : K_POS;
         else
            cg = rand_data();
         cyc(cg, inv, v, sd, lb);
         if (v) ph = 1 - ph;
      end

      repeat (3) idle();
      @(negedge GTX_CLK);
      #1;
      chk("q_drain", q.size(), 0);
      chk("lost_pulses", n_pulse, m_lost);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
